// File: rtl/ntsc_pattern_sequencer_pkg.sv
// Shared types and constants for the NTSC test-pattern sequencer.
// Holds the sequencer state encoding, the black pixel value and the frame origin.
package ntsc_pattern_sequencer_pkg;

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } seq_state_t;

    localparam logic [7:0] RGB_BLACK = 8'h00;
    localparam logic [9:0] X_ORIGIN  = 10'd0;
    localparam logic [8:0] Y_ORIGIN  = 9'd0;

    // Round-robin successor of a source index.
    function automatic logic [2:0] next_sel(input logic [2:0] sel, input int unsigned num_src);
        return (sel == 3'(num_src - 1)) ? 3'd0 : sel + 3'd1;
    endfunction

endpackage

// File: rtl/ntsc_pattern_sequencer_if.sv
// Pixel-stream bundle between the pattern generators, the sequencer and ntsc.
// All source streams are pixel-aligned with x/y/active_video.
interface ntsc_pattern_sequencer_if #(
    parameter int NUM_SRC = 4
);
    logic [9:0]              x;
    logic [8:0]              y;
    logic                    active_video;
    logic [NUM_SRC-1:0][7:0] rgb_src;
    logic [7:0]              rgb;

    modport master (output x, y, active_video, rgb_src, input rgb);
    modport slave  (input x, y, active_video, rgb_src, output rgb);
endinterface

// File: rtl/ntsc_pattern_sequencer_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, rising-edge pulse.
// Reusable for any raw active-high button on the shield.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync      <= 2'b00;
            cnt       <= '0;
            level     <= 1'b0;
            btn_pulse <= 1'b0;
        end else begin
            sync      <= {sync[0], btn_raw};
            btn_pulse <= 1'b0;
            // Any sample agreeing with the current level restarts the count.
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt       <= '0;
                level     <= sync[1];
                btn_pulse <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ntsc_pattern_sequencer.sv
// Frame-synchronous source selector: shows one of NUM_SRC patterns, advancing on a
// debounced button or dwell timeout, with BLANK_FRAMES black frames at each switch.
module ntsc_pattern_sequencer
    import ntsc_pattern_sequencer_pkg::*;
#(
    parameter int NUM_SRC         = 4,
    parameter int DWELL_FRAMES    = 300,
    parameter int BLANK_FRAMES    = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ntsc_pattern_sequencer_if.slave  vid,
    input  logic                     btn_next,
    input  logic                     auto_en,
    output logic [2:0]               pattern_sel,
    output logic                     blanking
);
    localparam int DW = $clog2(DWELL_FRAMES + 1);
    localparam int BW = $clog2(BLANK_FRAMES + 1);

    seq_state_t    state, state_nxt;
    logic [2:0]    sel_nxt;
    logic [DW-1:0] dwell_cnt, dwell_nxt;
    logic [BW-1:0] blank_cnt, blank_nxt;
    logic          adv_pend, pend_nxt;
    logic          org, org_q, frame_start;
    logic          btn_pulse;
    logic [7:0]    src_pix;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_next),
        .btn_pulse (btn_pulse)
    );

    assign org         = (vid.x == X_ORIGIN) && (vid.y == Y_ORIGIN);
    assign frame_start = org && !org_q;
    assign blanking    = (state == ST_BLANK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_SHOW;
            pattern_sel <= 3'd0;
            dwell_cnt   <= '0;
            blank_cnt   <= '0;
            adv_pend    <= 1'b0;
            org_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            pattern_sel <= sel_nxt;
            dwell_cnt   <= dwell_nxt;
            blank_cnt   <= blank_nxt;
            adv_pend    <= pend_nxt;
            org_q       <= org;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = pattern_sel;
        dwell_nxt = dwell_cnt;
        blank_nxt = blank_cnt;
        pend_nxt  = adv_pend;
        if (state == ST_SHOW && btn_pulse)
            pend_nxt = 1'b1;
        if (frame_start) begin
            case (state)
                ST_SHOW: begin
                    // Entering BLANK wins over any same-cycle request.
                    if (adv_pend) begin
                        state_nxt = ST_BLANK;
                        blank_nxt = '0;
                        sel_nxt   = next_sel(pattern_sel, NUM_SRC);
                        pend_nxt  = 1'b0;
                    end else if (auto_en) begin
                        if (dwell_cnt == DW'(DWELL_FRAMES - 1)) begin
                            dwell_nxt = '0;
                            pend_nxt  = 1'b1;
                        end else begin
                            dwell_nxt = dwell_cnt + 1'b1;
                        end
                    end else begin
                        dwell_nxt = '0;
                    end
                end
                ST_BLANK: begin
                    if (blank_cnt == BW'(BLANK_FRAMES - 1)) begin
                        state_nxt = ST_SHOW;
                        dwell_nxt = '0;
                    end else begin
                        blank_nxt = blank_cnt + 1'b1;
                    end
                end
                default: state_nxt = ST_SHOW;
            endcase
        end
    end

    always_comb begin
        src_pix = RGB_BLACK;
        for (int k = 0; k < NUM_SRC; k++)
            if (pattern_sel == 3'(k)) src_pix = vid.rgb_src[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vid.rgb <= RGB_BLACK;
        else
            vid.rgb <= (vid.active_video && state == ST_SHOW) ? src_pix : RGB_BLACK;
    end

endmodule

// File: tb/tb_ntsc_pattern_sequencer.sv
// Bench for ntsc_pattern_sequencer: short synthetic frames, frame-level reference model,
// every clock checks rgb / pattern_sel / blanking.
module tb_ntsc_pattern_sequencer;
    localparam int NUM_SRC = 4, DWELL = 3, BLANK = 2, DEB = 4;
    localparam int W = 8, H = 4, FR = W * H;

    logic       clk = 1'b0, rst_n = 1'b0, btn_next = 1'b0, auto_en = 1'b0;
    logic [2:0] pattern_sel;
    logic       blanking;

    ntsc_pattern_sequencer_if #(.NUM_SRC(NUM_SRC)) vid ();

    ntsc_pattern_sequencer #(
        .NUM_SRC(NUM_SRC), .DWELL_FRAMES(DWELL), .BLANK_FRAMES(BLANK), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vid(vid), .btn_next(btn_next),
        .auto_en(auto_en), .pattern_sel(pattern_sel), .blanking(blanking)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    // frame-level reference model
    int m_sel, m_dwell, m_bcnt;
    bit m_show, m_pend, m_org_q, rand_src, last_hit;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_sel = 0; m_dwell = 0; m_bcnt = 0;
        m_show = 1; m_pend = 0; m_org_q = 0;
    endtask

    task automatic frame_step();
        if (m_show) begin
            if (m_pend) begin
                m_show = 0; m_pend = 0; m_bcnt = 0;
                m_sel = (m_sel + 1) % NUM_SRC;
            end else if (auto_en) begin
                m_dwell++;
                if (m_dwell == DWELL) begin m_dwell = 0; m_pend = 1; end
            end else begin
                m_dwell = 0;
            end
        end else begin
            if (m_bcnt == BLANK - 1) begin m_show = 1; m_dwell = 0; end
            else m_bcnt++;
        end
    endtask

    task automatic tick(input int xx, input int yy, input bit av, input bit b);
        logic [7:0] src [NUM_SRC];
        logic [7:0] exp_rgb;
        bit org;
        vid.x = 10'(xx); vid.y = 9'(yy); vid.active_video = av; btn_next = b;
        for (int k = 0; k < NUM_SRC; k++) begin
            src[k] = rand_src ? 8'($urandom) : 8'(16 * (k + 1));
            vid.rgb_src[k] = src[k];
        end
        org = (xx == 0 && yy == 0);
        if (!rst_n) begin
            m_reset();
            exp_rgb = 8'h00;
        end else begin
            exp_rgb = (av && m_show) ? src[m_sel] : 8'h00;
            if (org && !m_org_q) frame_step();
            m_org_q = org;
        end
        @(posedge clk); #1;
        chk("rgb", 32'(vid.rgb), 32'(exp_rgb));
        chk("sel", 32'(pattern_sel), 32'(m_sel));
        chk("blanking", 32'(blanking), 32'(!m_show));
    endtask

    // mode: 0 idle, 1 press of len clks, 2 bounce 20 clks, 3 press only if pend already set
    task automatic run_span(input int mode, input int len, input int i0, input int i1);
        bit b, press;
        press = 0;
        for (int i = i0; i < i1; i++) begin
            if (i == 2) begin
                press = (mode == 1) || (mode == 3 && m_show && m_pend);
                last_hit = press;
                if (press && len >= DEB && m_show) m_pend = 1;
            end
            b = 0;
            if (press && i >= 2 && i < 2 + len) b = 1;
            if (mode == 2 && i >= 2 && i < 22) b = (i % 2 == 0);
            tick(i % W, i / W, (i % W != 0) && ($urandom_range(0, 3) != 0), b);
        end
    endtask

    task automatic run_frame(input int mode, input int len);
        run_span(mode, len, 0, FR);
    endtask

    initial begin
        bit found;
        int exp_sel;
        m_reset();
        rand_src = 0;
        vid.x = '0; vid.y = '0; vid.active_video = 0; vid.rgb_src = '0;

        // power-up reset, released mid-frame
        run_span(0, 0, 0, 5);
        rst_n = 1;
        run_span(0, 0, 5, FR);

        // auto advance through all sources and the wrap
        auto_en = 1;
        for (int f = 0; f < 24; f++) begin
            run_frame(0, 0);
            if (f == 2)  begin chk("auto_f2_sel", 32'(pattern_sel), 0); chk("auto_f2_blk", 32'(blanking), 0); end
            if (f == 3)  begin chk("auto_f3_sel", 32'(pattern_sel), 1); chk("auto_f3_blk", 32'(blanking), 1); end
            if (f == 5)  begin chk("auto_f5_sel", 32'(pattern_sel), 1); chk("auto_f5_blk", 32'(blanking), 0); end
            if (f == 21) begin chk("wrap_sel", 32'(pattern_sel), 0); chk("wrap_blk", 32'(blanking), 1); end
            if (f == 23) begin chk("wrap_show", 32'(blanking), 0); end
        end
        repeat (6) run_frame(0, 0);

        // reset mid-frame while showing source 1
        run_span(0, 0, 0, 13);
        rst_n = 0; #1;
        chk("rst_rgb", 32'(vid.rgb), 0);
        chk("rst_sel", 32'(pattern_sel), 0);
        chk("rst_blk", 32'(blanking), 0);
        run_span(0, 0, 13, 17);
        rst_n = 1;
        auto_en = 0;
        tick(17 % W, 17 / W, 1'b1, 1'b0);
        chk("rst_first_px", 32'(vid.rgb), 32'h10);
        run_span(0, 0, 18, FR);

        // button: short press, valid press, bounce
        run_frame(1, 3); run_frame(0, 0);
        chk("btn_short_sel", 32'(pattern_sel), 0);
        run_frame(1, 6);
        chk("btn_wait_sel", 32'(pattern_sel), 0);
        run_frame(0, 0);
        chk("btn_adv_sel", 32'(pattern_sel), 1); chk("btn_adv_blk", 32'(blanking), 1);
        run_frame(0, 0); run_frame(0, 0);
        chk("btn_show_blk", 32'(blanking), 0);
        run_frame(2, 0); run_frame(0, 0);
        chk("bounce_sel", 32'(pattern_sel), 1); chk("bounce_blk", 32'(blanking), 0);

        // coalesce: press in the expiry frame, then a press during BLANK
        auto_en = 1;
        found = 0;
        exp_sel = (m_sel + 1) % NUM_SRC;
        for (int f = 0; f < 8 && !found; f++) begin
            run_frame(3, 6);
            found = last_hit;
        end
        if (!found) chk("coal_timeout", 0, 1);
        run_frame(1, 6);
        chk("coal_sel", 32'(pattern_sel), 32'(exp_sel)); chk("coal_blk", 32'(blanking), 1);
        run_frame(0, 0); run_frame(0, 0);
        chk("coal_resume_sel", 32'(pattern_sel), 32'(exp_sel));
        chk("coal_resume_blk", 32'(blanking), 0);
        run_frame(0, 0);
        chk("coal_no_extra", 32'(blanking), 0);

        // auto_en dropped at dwell 2 restarts the dwell
        found = 0;
        for (int f = 0; f < 10 && !found; f++) begin
            run_frame(0, 0);
            found = m_show && !m_pend && (m_dwell == 2);
        end
        if (!found) chk("dwell_timeout", 0, 1);
        auto_en = 0; run_frame(0, 0);
        auto_en = 1;
        for (int f = 0; f < 3; f++) begin
            run_frame(0, 0);
            chk("dwell_restart_hold", 32'(blanking), 0);
        end
        run_frame(0, 0);
        chk("dwell_restart_adv", 32'(blanking), 1);

        // randomized source data, buttons and auto_en
        rand_src = 1;
        for (int f = 0; f < 40; f++) begin
            auto_en = ($urandom_range(0, 3) != 0);
            run_frame($urandom_range(0, 2), $urandom_range(1, 8));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
